ppu_write_queue: RTL and testbench

- Sits between the Avalon-MM slave interface and the PPU sprite-attribute, sprite-pattern and color-table memories.
- Buffers host writes in a FIFO.
- Replays the buffered writes to the memory write port only during vertical blank, one committed frame at a time, so sprite and palette updates never tear mid-frame.
- The host closes a frame by writing to the commit region.

---
 rtl/ppu_write_queue.sv | 132 +++++++++++++
 tb/tb_ppu_write_queue.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_write_queue.sv
// Host write buffer for the PPU sprite/color memories: host writes are queued and
// replayed to the memory port one committed frame per vertical blank, so updates never tear.
module ppu_write_queue #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          chipselect,
  input  logic          write,
  input  logic [15:0]   address,
  input  logic [31:0]   writedata,
  output logic          waitrequest,
  input  logic [9:0]    vcount,
  output logic [2:0]    mem_write,
  output logic [15:0]   w_addr,
  output logic [31:0]   w_data,
  output logic [AW:0]   level,
  output logic [AW:0]   pending_frames
);

  typedef enum logic [1:0] {
    WAIT_VB,
    DRAIN,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  // Entry layout: {marker, address[15:0], writedata[31:0]}
  logic [48:0]   fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [48:0]   push_entry;
  logic [48:0]   head;
  logic          push;
  logic          pop;
  logic          push_marker;
  logic          pop_marker;
  logic          in_window;
  logic [2:0]    strobe_next;
  logic          load_next;

  // Stall decision uses the registered level only; a same-cycle pop does not free a slot.
  assign waitrequest = chipselect && write && (level == (AW+1)'(DEPTH));
  assign push        = chipselect && write && !waitrequest;
  assign push_marker = push && (address[9:8] == 2'b11);
  assign push_entry  = push_marker ? {1'b1, address, 32'd0} : {1'b0, address, writedata};

  assign head       = fifo_mem[rd_ptr];
  assign pop        = (state == DRAIN) && (level != '0);
  assign pop_marker = pop && head[48];

  // Line 524 is excluded so a drain always has a full line left before vcount wraps.
  assign in_window = (vcount >= 10'd480) && (vcount <= 10'd523);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      level          <= '0;
      pending_frames <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      case ({push_marker, pop_marker})
        2'b10:   pending_frames <= pending_frames + 1'b1;
        2'b01:   pending_frames <= pending_frames - 1'b1;
        default: pending_frames <= pending_frames;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= WAIT_VB;
    end else begin
      state <= state_next;
    end
  end

  // DONE holds off until the next frame starts, so at most one frame drains per vblank.
  always_comb begin
    state_next = state;
    case (state)
      WAIT_VB: if ((pending_frames != '0) && in_window) state_next = DRAIN;
      DRAIN:   if (pop_marker) state_next = DONE;
      DONE:    if (vcount == 10'd0) state_next = WAIT_VB;
      default: state_next = WAIT_VB;
    endcase
  end

  always_comb begin
    strobe_next = 3'b000;
    load_next   = 1'b0;
    if (pop && !head[48]) begin
      load_next   = 1'b1;
      strobe_next = 3'b001 << head[41:40];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_write <= 3'b000;
      w_addr    <= 16'd0;
      w_data    <= 32'd0;
    end else begin
      mem_write <= strobe_next;
      if (load_next) begin
        w_addr <= head[47:32];
        w_data <= head[31:0];
      end
    end
  end

endmodule

// File: tb/tb_ppu_write_queue.sv
// Bench for ppu_write_queue: host traffic feeds a frame-level reference model whose
// expected memory writes are checked by a scoreboard monitor on the memory port.
module tb_ppu_write_queue;

  localparam int DEPTH      = 64;
  localparam int AW         = 6;
  localparam int WAIT_LIMIT = 4000;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    int          frame;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        chipselect = 1'b0;
  logic        write = 1'b0;
  logic [15:0] address = 16'd0;
  logic [31:0] writedata = 32'd0;
  logic [9:0]  vcount = 10'd0;
  logic        waitrequest;
  logic [2:0]  mem_write;
  logic [15:0] w_addr;
  logic [31:0] w_data;
  logic [AW:0] level;
  logic [AW:0] pending_frames;

  int checks = 0;
  int fails = 0;

  // Reference model: open (uncommitted) writes, committed writes tagged with frame id,
  // entry count per frame, and which frame the current vblank is expected to drain.
  wr_t exp_q[$];
  wr_t open_q[$];
  int  fsize[$];
  int  committed = 0;
  int  drained = 0;
  int  model_level = 0;
  int  vb_frame = -1;

  always #5 clk = ~clk;

  ppu_write_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk),
    .reset(reset),
    .chipselect(chipselect),
    .write(write),
    .address(address),
    .writedata(writedata),
    .waitrequest(waitrequest),
    .vcount(vcount),
    .mem_write(mem_write),
    .w_addr(w_addr),
    .w_data(w_data),
    .level(level),
    .pending_frames(pending_frames)
  );

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int line_len(input logic [9:0] v);
    return (v >= 10'd523) ? 100 : 3;
  endfunction

  function automatic logic [15:0] rand_addr(input logic [1:0] region);
    logic [15:0] r;
    r      = 16'($urandom);
    r[9:8] = region;
    return r;
  endfunction

  task automatic frame_boundary();
    if (vb_frame >= 0) begin
      check_output("frame_drained", (exp_q.size() > 0) ? (exp_q[0].frame == vb_frame) : 1'b0, 0);
      model_level -= fsize[vb_frame];
      drained++;
      vb_frame = -1;
    end
    check_output("level_at_frame", level, model_level);
    check_output("pending_at_frame", pending_frames, committed - drained);
  endtask

  // Scaled VGA line counter; the last two lines are long so a drain entered on line 523
  // still completes before vcount wraps.
  initial begin
    int line_cnt;
    line_cnt = 0;
    forever begin
      @(negedge clk);
      line_cnt++;
      if (line_cnt >= line_len(vcount)) begin
        line_cnt = 0;
        vcount   = (vcount == 10'd524) ? 10'd0 : vcount + 10'd1;
        if (vcount == 10'd0) frame_boundary();
      end
      if (vcount >= 10'd480 && vcount <= 10'd523 && vb_frame < 0 && committed > drained)
        vb_frame = drained;
    end
  end

  always @(negedge clk) begin
    wr_t e;
    #1;
    if (reset && mem_write != 3'b000) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_strobe", {mem_write, w_addr, w_data}, 0);
      end else begin
        e = exp_q.pop_front();
        check_output("strobe_data", {mem_write, w_addr, w_data},
                     {3'b001 << e.addr[9:8], e.addr, e.data});
        check_output("strobe_frame", e.frame, vb_frame);
        check_output("strobe_line", (vcount >= 10'd480 && vcount <= 10'd524), 1);
      end
    end
  end

  task automatic apply_stimulus(input logic [15:0] a, input logic [31:0] d, output int stalls);
    bit  done;
    wr_t e;
    done   = 1'b0;
    stalls = 0;
    @(negedge clk);
    chipselect = 1'b1;
    write      = 1'b1;
    address    = a;
    writedata  = d;
    while (!done && stalls <= WAIT_LIMIT) begin
      #1;
      if (!waitrequest) begin
        @(posedge clk);
        done = 1'b1;
      end else begin
        stalls++;
        @(negedge clk);
      end
    end
    #1;
    chipselect = 1'b0;
    write      = 1'b0;
    if (!done) begin
      check_output("write_accept_timeout", stalls, 0);
    end else begin
      if (a[9:8] == 2'b11) begin
        fsize.push_back(open_q.size() + 1);
        while (open_q.size() > 0) begin
          e       = open_q.pop_front();
          e.frame = committed;
          exp_q.push_back(e);
        end
        committed++;
      end else begin
        e.addr  = a;
        e.data  = d;
        e.frame = -1;
        open_q.push_back(e);
      end
      model_level++;
    end
  endtask

  task automatic write_random(input int n);
    int st;
    for (int i = 0; i < n; i++)
      apply_stimulus(rand_addr(2'($urandom_range(0, 2))), $urandom, st);
  endtask

  task automatic commit();
    int st;
    apply_stimulus(rand_addr(2'b11), $urandom, st);
  endtask

  task automatic wait_line(input logic [9:0] v);
    logic [9:0] prev;
    int         n;
    bit         hit;
    prev = vcount;
    n    = 0;
    hit  = 1'b0;
    while (!hit && n < WAIT_LIMIT) begin
      @(negedge clk);
      #1;
      n++;
      hit  = (vcount == v) && (prev != v);
      prev = vcount;
    end
    check_output("wait_vcount", vcount, v);
  endtask

  initial begin
    int st;
    int stalled_early;
    int stall65;
    logic [9:0] line65;
    int n;

    repeat (5) @(negedge clk);
    #1;
    check_output("reset_mem_write", mem_write, 0);
    check_output("reset_w_addr", w_addr, 0);
    check_output("reset_w_data", w_data, 0);
    check_output("reset_level", level, 0);
    check_output("reset_pending", pending_frames, 0);
    check_output("reset_waitrequest", waitrequest, 0);
    @(negedge clk);
    reset = 1'b1;
    wait_line(0);
    wait_line(0);

    $display("[TB] single committed frame");
    wait_line(100);
    apply_stimulus(16'h0003, 32'h12345678, st);
    apply_stimulus(16'h0201, 32'h00FF00FF, st);
    apply_stimulus(16'h0300, $urandom, st);
    wait_line(0);

    $display("[TB] uncommitted data");
    wait_line(10);
    for (int i = 0; i < 5; i++) apply_stimulus(rand_addr(2'b01), $urandom, st);
    wait_line(0);
    wait_line(0);
    wait_line(0);
    check_output("uncommitted_level", level, model_level);

    $display("[TB] three frames queued");
    commit();
    write_random(2);
    commit();
    write_random(1);
    commit();
    wait_line(0);
    wait_line(0);
    wait_line(0);

    $display("[TB] backpressure");
    wait_line(5);
    write_random(9);
    commit();
    stalled_early = 0;
    stall65 = 0;
    line65 = 10'd0;
    for (int i = 0; i < 60; i++) begin
      apply_stimulus(rand_addr(2'($urandom_range(0, 2))), $urandom, st);
      if (i < 54 && st != 0) stalled_early++;
      if (i == 54) begin
        stall65 = st;
        line65  = vcount;
      end
    end
    check_output("no_stall_first_64", stalled_early, 0);
    check_output("stall_on_65th", stall65 > 50, 1);
    check_output("65th_accepted_in_vblank", line65 >= 10'd480, 1);
    commit();
    wait_line(0);
    wait_line(0);

    $display("[TB] commit on line 524");
    wait_line(20);
    write_random(2);
    wait_line(524);
    repeat (5) @(negedge clk);
    commit();
    wait_line(0);
    wait_line(0);

    $display("[TB] reset during drain");
    wait_line(10);
    write_random(20);
    commit();
    write_random(3);
    commit();
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (mem_write == 3'b000 && n < WAIT_LIMIT);
    check_output("drain_started", mem_write != 3'b000, 1);
    #2;
    reset = 1'b0;
    #1;
    check_output("midreset_mem_write", mem_write, 0);
    check_output("midreset_w_addr", w_addr, 0);
    check_output("midreset_w_data", w_data, 0);
    check_output("midreset_level", level, 0);
    check_output("midreset_pending", pending_frames, 0);
    exp_q.delete();
    open_q.delete();
    fsize.delete();
    committed   = 0;
    drained     = 0;
    model_level = 0;
    vb_frame    = -1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    wait_line(0);
    wait_line(0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
